// File: rtl/ds_operand_collect.sv
// Decode-stage pipeline register with operand collection.
// Holds {inst,pc} from IF, resolves rs/rt from the youngest matching bypass
// source or the regfile, stalls when the winning source is not ready, and
// keeps a saturating count of stalled cycles.
module ds_operand_collect #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic                                  fs_to_ds_valid,
  input  logic [31:0]                           fs_inst,
  input  logic [31:0]                           fs_pc,
  output logic                                  ds_allowin,
  input  logic                                  es_allowin,
  output logic                                  ds_to_es_valid,
  output logic [31:0]                           ds_inst,
  output logic [31:0]                           ds_pc,
  input  logic                                  rs_used,
  input  logic                                  rt_used,
  output logic [REG_AW-1:0]                     rf_raddr1,
  output logic [REG_AW-1:0]                     rf_raddr2,
  input  logic [DATA_W-1:0]                     rf_rdata1,
  input  logic [DATA_W-1:0]                     rf_rdata2,
  input  logic [NUM_FWD*(2+REG_AW+DATA_W)-1:0]  fwd_bus,
  output logic [DATA_W-1:0]                     rs_value,
  output logic [DATA_W-1:0]                     rt_value,
  output logic [CNT_W-1:0]                      stall_cnt
);

  localparam int SRC_W = 2 + REG_AW + DATA_W;

  typedef struct packed {
    logic              hit;
    logic              rdy;
    logic [DATA_W-1:0] data;
  } fwd_res_t;

  logic                             ds_valid_q, ds_valid_d;
  logic [31:0]                      ds_inst_q, ds_inst_d;
  logic [31:0]                      ds_pc_q, ds_pc_d;
  logic [CNT_W-1:0]                 stall_cnt_q, stall_cnt_d;

  logic [NUM_FWD-1:0]               src_vld;
  logic [NUM_FWD-1:0]               src_rdy;
  logic [NUM_FWD-1:0][REG_AW-1:0]   src_dst;
  logic [NUM_FWD-1:0][DATA_W-1:0]   src_dat;

  logic [REG_AW-1:0]                rs_addr, rt_addr;
  fwd_res_t                         rs_res, rt_res;
  logic                             blocked;
  logic                             ready_go;
  logic                             load_en;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Youngest matching source wins: scan oldest to youngest so the last hit
  // written is the lowest index. Register 0 and unused operands never match.
  function automatic fwd_res_t pick_src(
    input logic [REG_AW-1:0]               addr,
    input logic                            used,
    input logic [NUM_FWD-1:0]              vld,
    input logic [NUM_FWD-1:0]              rdy,
    input logic [NUM_FWD-1:0][REG_AW-1:0]  dst,
    input logic [NUM_FWD-1:0][DATA_W-1:0]  dat
  );
    fwd_res_t res;
    res = '0;
    if (used && (addr != '0)) begin
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (vld[i] && (dst[i] == addr)) begin
          res.hit  = 1'b1;
          res.rdy  = rdy[i];
          res.data = dat[i];
        end
      end
    end
    return res;
  endfunction

  // Split the flat bypass bus into per-source fields ({valid,ready,dest,data}).
  always_comb begin
    src_vld = '0;
    src_rdy = '0;
    src_dst = '0;
    src_dat = '0;
    for (int i = 0; i < NUM_FWD; i++) begin
      src_dat[i] = fwd_bus[i*SRC_W +: DATA_W];
      src_dst[i] = fwd_bus[i*SRC_W + DATA_W +: REG_AW];
      src_rdy[i] = fwd_bus[i*SRC_W + DATA_W + REG_AW];
      src_vld[i] = fwd_bus[i*SRC_W + DATA_W + REG_AW + 1];
    end
  end

  assign rs_addr = ds_inst_q[21 +: REG_AW];
  assign rt_addr = ds_inst_q[16 +: REG_AW];

  // Resolve both operands every cycle; nothing is captured while stalled.
  always_comb begin
    rs_res = pick_src(rs_addr, rs_used, src_vld, src_rdy, src_dst, src_dat);
    rt_res = pick_src(rt_addr, rt_used, src_vld, src_rdy, src_dst, src_dat);

    if (rs_addr == '0)  rs_value = '0;
    else if (rs_res.hit) rs_value = rs_res.data;
    else                 rs_value = rf_rdata1;

    if (rt_addr == '0)  rt_value = '0;
    else if (rt_res.hit) rt_value = rt_res.data;
    else                 rt_value = rf_rdata2;
  end

  // Handshake: a not-ready winner blocks even when an older source has the value.
  always_comb begin
    blocked        = ds_valid_q & ((rs_res.hit & ~rs_res.rdy) |
                                   (rt_res.hit & ~rt_res.rdy));
    ready_go       = ~blocked;
    ds_allowin     = ~ds_valid_q | (ready_go & es_allowin);
    ds_to_es_valid = ds_valid_q & ready_go & ~flush;
    load_en        = fs_to_ds_valid & ds_allowin;
  end

  // Next-state: flush overrides the valid bit; payload and counter update independently.
  always_comb begin
    ds_valid_d  = ds_valid_q;
    ds_inst_d   = ds_inst_q;
    ds_pc_d     = ds_pc_q;
    stall_cnt_d = stall_cnt_q;

    if (ds_allowin) ds_valid_d = fs_to_ds_valid;
    if (flush)      ds_valid_d = 1'b0;

    if (load_en) begin
      ds_inst_d = fs_inst;
      ds_pc_d   = fs_pc;
    end

    if (blocked && !flush) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_valid_q  <= 1'b0;
      ds_inst_q   <= '0;
      ds_pc_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      ds_valid_q  <= ds_valid_d;
      ds_inst_q   <= ds_inst_d;
      ds_pc_q     <= ds_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ds_inst   = ds_inst_q;
  assign ds_pc     = ds_pc_q;
  assign rf_raddr1 = rs_addr;
  assign rf_raddr2 = rt_addr;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ds_operand_collect.sv
// Bench for ds_operand_collect: directed scenarios with literal expectations,
// plus a per-cycle comparison against a behavioural model. A second instance
// with a 2-bit stall counter shares the stimulus to cover saturation.
module tb_ds_operand_collect;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NF = 3;
  localparam int SW = 2 + AW + DW;

  localparam logic [31:0] INST_A = 32'h0022_1821; // addu r3,r1,r2
  localparam logic [31:0] INST_B = 32'h0043_1021; // addu r2,r2,r3
  localparam logic [31:0] INST_C = 32'h0002_1821; // addu r3,r0,r2

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic fs_to_ds_valid = 1'b0;
  logic es_allowin = 1'b1;
  logic rs_used = 1'b1;
  logic rt_used = 1'b1;
  logic [31:0] fs_inst = '0;
  logic [31:0] fs_pc = '0;
  logic run = 1'b0;

  logic          src_v [NF];
  logic          src_r [NF];
  logic [AW-1:0] src_d [NF];
  logic [DW-1:0] src_x [NF];
  logic [DW-1:0] rf [32];
  logic [NF*SW-1:0] fwd_bus;

  logic ds_allowin, ds_to_es_valid;
  logic [31:0] ds_inst, ds_pc;
  logic [AW-1:0] rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_rdata1, rf_rdata2, rs_value, rt_value;
  logic [15:0] stall_cnt;

  logic d2_allowin, d2_to_es_valid;
  logic [31:0] d2_inst, d2_pc;
  logic [AW-1:0] d2_raddr1, d2_raddr2;
  logic [DW-1:0] d2_rdata1, d2_rdata2, d2_rs, d2_rt;
  logic [1:0] d2_stall_cnt;

  int n_chk = 0;
  int n_pass = 0;

  // Behavioural model state: held instruction and raw number of stalled cycles.
  logic        m_valid;
  logic [31:0] m_inst, m_pc;
  int          m_stalls;

  always #5 clk = ~clk;

  always_comb begin
    fwd_bus = '0;
    for (int i = 0; i < NF; i++) fwd_bus[i*SW +: SW] = {src_v[i], src_r[i], src_d[i], src_x[i]};
  end

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  assign d2_rdata1 = rf[d2_raddr1];
  assign d2_rdata2 = rf[d2_raddr2];

  ds_operand_collect #(.DATA_W(DW), .REG_AW(AW), .NUM_FWD(NF), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .fs_to_ds_valid(fs_to_ds_valid),
    .fs_inst(fs_inst), .fs_pc(fs_pc), .ds_allowin(ds_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_inst(ds_inst), .ds_pc(ds_pc),
    .rs_used(rs_used), .rt_used(rt_used), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_bus(fwd_bus),
    .rs_value(rs_value), .rt_value(rt_value), .stall_cnt(stall_cnt)
  );

  ds_operand_collect #(.DATA_W(DW), .REG_AW(AW), .NUM_FWD(NF), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .fs_to_ds_valid(fs_to_ds_valid),
    .fs_inst(fs_inst), .fs_pc(fs_pc), .ds_allowin(d2_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(d2_to_es_valid), .ds_inst(d2_inst), .ds_pc(d2_pc),
    .rs_used(rs_used), .rt_used(rt_used), .rf_raddr1(d2_raddr1), .rf_raddr2(d2_raddr2),
    .rf_rdata1(d2_rdata1), .rf_rdata2(d2_rdata2), .fwd_bus(fwd_bus),
    .rs_value(d2_rs), .rt_value(d2_rt), .stall_cnt(d2_stall_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Operand lookup: {stalls, value}. First valid source with the register wins.
  function automatic logic [32:0] resolve(input logic [4:0] a, input logic used);
    if (a == 5'd0) return 33'd0;
    if (used)
      for (int i = 0; i < NF; i++)
        if (src_v[i] && src_d[i] == a) return {~src_r[i], src_x[i]};
    return {1'b0, rf[a]};
  endfunction

  task automatic model_now(output logic blk, output logic allow, output logic tov,
                           output logic [31:0] rsv, output logic [31:0] rtv);
    logic [32:0] rs_r, rt_r;
    rs_r  = resolve(m_inst[25:21], rs_used);
    rt_r  = resolve(m_inst[20:16], rt_used);
    rsv   = rs_r[31:0];
    rtv   = rt_r[31:0];
    blk   = m_valid && (rs_r[32] || rt_r[32]);
    allow = !m_valid || (!blk && es_allowin);
    tov   = m_valid && !blk && !flush;
  endtask

  // Model update at each edge.
  always @(posedge clk or posedge reset) begin
    logic blk, allow, tov;
    logic [31:0] rsv, rtv;
    if (reset) begin
      m_valid  <= 1'b0;
      m_inst   <= '0;
      m_pc     <= '0;
      m_stalls <= 0;
    end else begin
      model_now(blk, allow, tov, rsv, rtv);
      if (flush) m_valid <= 1'b0;
      else if (allow) m_valid <= fs_to_ds_valid;
      if (allow && fs_to_ds_valid) begin
        m_inst <= fs_inst;
        m_pc   <= fs_pc;
      end
      if (blk && !flush) m_stalls <= m_stalls + 1;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic blk, allow, tov;
    logic [31:0] rsv, rtv;
    if (run && !reset) begin
      model_now(blk, allow, tov, rsv, rtv);
      chk("cyc_allowin", ds_allowin, allow);
      chk("cyc_to_es_valid", ds_to_es_valid, tov);
      chk("cyc_inst", ds_inst, m_inst);
      chk("cyc_pc", ds_pc, m_pc);
      chk("cyc_raddr1", rf_raddr1, m_inst[25:21]);
      chk("cyc_raddr2", rf_raddr2, m_inst[20:16]);
      chk("cyc_rs", rs_value, rsv);
      chk("cyc_rt", rt_value, rtv);
      chk("cyc_stall16", stall_cnt, (m_stalls > 65535) ? 65535 : m_stalls);
      chk("cyc_d2_to_es_valid", d2_to_es_valid, tov);
      chk("cyc_stall2", d2_stall_cnt, (m_stalls > 3) ? 3 : m_stalls);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic r,
                         input logic [4:0] d, input logic [31:0] x);
    src_v[i] = v; src_r[i] = r; src_d[i] = d; src_x[i] = x;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NF; i++) set_src(i, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'hDEAD_0000;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    rf[3] = 32'd9;
    clear_src();

    // Reset state
    #2 reset = 1'b1;
    step();
    chk("rst_allowin", ds_allowin, 1);
    chk("rst_to_es_valid", ds_to_es_valid, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_inst", ds_inst, 0);
    chk("rst_pc", ds_pc, 0);
    reset = 1'b0;
    run = 1'b1;
    step();

    // 1: no hazard, issued in the load cycle
    fs_inst = INST_A; fs_pc = 32'hBFC0_0000; fs_to_ds_valid = 1'b1;
    step();
    fs_to_ds_valid = 1'b0;
    #1;
    chk("t1_to_es_valid", ds_to_es_valid, 1);
    chk("t1_rs", rs_value, 32'd5);
    chk("t1_rt", rt_value, 32'd7);
    chk("t1_pc", ds_pc, 32'hBFC0_0000);
    step();
    chk("t1_drained", ds_to_es_valid, 0);

    // 2: youngest source wins, then next one when it drops out
    set_src(0, 1, 1, 5'd1, 32'hAA);
    set_src(2, 1, 1, 5'd1, 32'hCC);
    es_allowin = 1'b0;
    fs_inst = INST_A; fs_pc = 32'hBFC0_0010; fs_to_ds_valid = 1'b1;
    step();
    fs_to_ds_valid = 1'b0;
    #1;
    chk("t2_rs_src0", rs_value, 32'hAA);
    chk("t2_allowin_hold", ds_allowin, 0);
    src_v[0] = 1'b0;
    #1;
    chk("t2_rs_src2", rs_value, 32'hCC);
    chk("t2_rt_rf", rt_value, 32'd7);
    es_allowin = 1'b1;
    step();
    clear_src();

    // 3: load-use stall for two cycles, IF held off, then back-to-back issue
    set_src(0, 1, 0, 5'd2, 32'h1234);
    fs_inst = INST_A; fs_pc = 32'hBFC0_0020; fs_to_ds_valid = 1'b1;
    step();
    fs_inst = INST_B; fs_pc = 32'hBFC0_0024;
    #1;
    chk("t3_allowin_c1", ds_allowin, 0);
    chk("t3_to_es_c1", ds_to_es_valid, 0);
    step();
    #1;
    chk("t3_allowin_c2", ds_allowin, 0);
    chk("t3_inst_held", ds_inst, INST_A);
    chk("t3_stall_c2", stall_cnt, 1);
    step();
    set_src(0, 1, 1, 5'd2, 32'h55);
    #1;
    chk("t3_allowin_go", ds_allowin, 1);
    chk("t3_to_es_go", ds_to_es_valid, 1);
    chk("t3_rt_fwd", rt_value, 32'h55);
    chk("t3_stall_cnt", stall_cnt, 2);
    step();
    fs_to_ds_valid = 1'b0;
    #1;
    chk("t3_next_inst", ds_inst, INST_B);
    chk("t3_next_rs", rs_value, 32'h55);
    chk("t3_next_rt", rt_value, 32'd9);
    step();
    clear_src();

    // 4: register 0 and unused operands never stall
    set_src(0, 1, 0, 5'd0, 32'h99);
    es_allowin = 1'b0;
    fs_inst = INST_C; fs_pc = 32'hBFC0_0030; fs_to_ds_valid = 1'b1;
    step();
    fs_to_ds_valid = 1'b0;
    #1;
    chk("t4_r0_to_es", ds_to_es_valid, 1);
    chk("t4_r0_value", rs_value, 32'd0);
    set_src(0, 1, 0, 5'd2, 32'h77);
    rt_used = 1'b0;
    #1;
    chk("t4_unused_to_es", ds_to_es_valid, 1);
    chk("t4_unused_rt", rt_value, 32'd7);
    step();
    chk("t4_hold_no_count", stall_cnt, 2);
    es_allowin = 1'b1;
    step();
    rt_used = 1'b1;
    clear_src();

    // 5: flush while blocked drops the instruction without counting
    set_src(1, 1, 0, 5'd1, 32'h4444);
    fs_inst = INST_A; fs_pc = 32'hBFC0_0040; fs_to_ds_valid = 1'b1;
    step();
    fs_to_ds_valid = 1'b0;
    #1;
    chk("t5_blocked", ds_allowin, 0);
    flush = 1'b1;
    #1;
    chk("t5_flush_to_es", ds_to_es_valid, 0);
    step();
    flush = 1'b0;
    #1;
    chk("t5_stall_unchanged", stall_cnt, 2);
    chk("t5_dropped_allowin", ds_allowin, 1);
    chk("t5_dropped_to_es", ds_to_es_valid, 0);
    clear_src();

    // 6: saturation of the 2-bit counter, then asynchronous reset mid-stall
    set_src(0, 1, 0, 5'd1, 32'h0);
    fs_inst = INST_A; fs_pc = 32'hBFC0_0050; fs_to_ds_valid = 1'b1;
    step();
    fs_to_ds_valid = 1'b0;
    repeat (5) step();
    #1;
    chk("t6_stall16", stall_cnt, 7);
    chk("t6_stall2_sat", d2_stall_cnt, 3);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_cnt", stall_cnt, 0);
    chk("t6_rst_cnt2", d2_stall_cnt, 0);
    chk("t6_rst_allowin", ds_allowin, 1);
    chk("t6_rst_to_es", ds_to_es_valid, 0);
    chk("t6_rst_inst", ds_inst, 0);
    step();
    reset = 1'b0;
    clear_src();
    step();

    // Normal operation after reset
    fs_inst = INST_B; fs_pc = 32'hBFC0_0060; fs_to_ds_valid = 1'b1;
    step();
    fs_to_ds_valid = 1'b0;
    #1;
    chk("post_rst_to_es", ds_to_es_valid, 1);
    chk("post_rst_rs", rs_value, 32'd7);
    chk("post_rst_rt", rt_value, 32'd9);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
